// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU, shift/saturate requantize to u8, then 2x2 stride-2
// max pooling over a raster-ordered conv result stream.
//
// Ports:
//   clk, rst      : single rising-edge clock, async active-high reset
//   start_signal  : arms a new frame (honoured only in IDLE)
//   result_in     : signed DATA_W-bit conv result
//   result_valid  : result_in valid this cycle (used only in RUN)
//   conv_done     : end-of-frame pulse from the conv engine
//   pool_out      : unsigned 8-bit pooled pixel
//   pool_valid    : one-cycle strobe per pooled pixel
//   pool_done     : one-cycle frame-complete pulse
//   frame_error   : sticky, frame ended short

module relu_maxpool_2x2 #(
  parameter int IN_WIDTH  = 30,
  parameter int IN_HEIGHT = 30,
  parameter int DATA_W    = 22,
  parameter int SHIFT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_signal,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_valid,
  input  logic              conv_done,
  output logic [7:0]        pool_out,
  output logic              pool_valid,
  output logic              pool_done,
  output logic              frame_error
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int CW     = $clog2(IN_WIDTH);
  localparam int RW     = $clog2(IN_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    hold;
  logic [7:0]    rowbuf [0:HALF_W-1];

  logic              accept;
  logic              last_smp;
  logic [DATA_W-1:0] relu_v;
  logic [DATA_W-1:0] shr_v;
  logic [7:0]        q;
  logic [7:0]        hmax;
  logic [7:0]        buf_rd;
  logic [7:0]        vmax;
  logic [CW-2:0]     bidx;

  // Datapath: ReLU, logical shift, then clamp to 8 bits.
  always_comb begin
    accept   = (state == S_RUN) && result_valid;
    last_smp = (col == COL_LAST) && (row == ROW_LAST);
    relu_v   = result_in[DATA_W-1] ? '0 : result_in;
    shr_v    = relu_v >> SHIFT;
    q        = (|shr_v[DATA_W-1:8]) ? 8'hFF : shr_v[7:0];
    hmax     = (hold > q) ? hold : q;
    bidx     = col[CW-1:1];
    buf_rd   = rowbuf[bidx];
    vmax     = (buf_rd > hmax) ? buf_rd : hmax;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      pool_out    <= '0;
      pool_valid  <= 1'b0;
      pool_done   <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < HALF_W; i++)
        rowbuf[i] <= '0;
    end else begin
      pool_valid <= 1'b0;
      pool_done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_signal) begin
            state       <= S_RUN;
            col         <= '0;
            row         <= '0;
            hold        <= '0;
            frame_error <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= last_smp ? '0 : row + ROW_ONE;
            end else begin
              col <= col + COL_ONE;
            end
            // Even column parks the left pixel; odd column closes
            // the horizontal pair. Even rows stash the pair max for
            // the row below, odd rows finish the 2x2 window.
            if (!col[0]) begin
              hold <= q;
            end else if (!row[0]) begin
              rowbuf[bidx] <= hmax;
            end else begin
              pool_out   <= vmax;
              pool_valid <= 1'b1;
            end
          end
          // The final sample wins over a same-cycle conv_done.
          if (accept && last_smp) begin
            state     <= S_DONE;
            pool_done <= 1'b1;
          end else if (conv_done) begin
            state       <= S_DONE;
            pool_done   <= 1'b1;
            frame_error <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: directed frames with hand-computed pooled outputs,
// gapped input latency, early end and mid-frame reset.

module tb_relu_maxpool_2x2;

  localparam int W = 30;
  localparam int H = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_signal;
  logic [21:0] result_in;
  logic        result_valid;
  logic        conv_done;
  logic [7:0]  pool_out;
  logic        pool_valid;
  logic        pool_done;
  logic        frame_error;

  relu_maxpool_2x2 dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .result_in    (result_in),
    .result_valid (result_valid),
    .conv_done    (conv_done),
    .pool_out     (pool_out),
    .pool_valid   (pool_valid),
    .pool_done    (pool_done),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int out_cnt, done_cnt, done_cyc, last_pv_cyc, lat_err;
  logic [7:0] outs [0:255];
  bit comp_flag = 1'b0;
  bit pv_exp    = 1'b0;
  bit lat_en    = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pool_valid === 1'b1) begin
      if (out_cnt < 256) outs[out_cnt] = pool_out;
      out_cnt++;
      last_pv_cyc = cyc;
    end
    if (pool_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (lat_en && (pool_valid !== pv_exp)) lat_err++;
    pv_exp = comp_flag && result_valid;
  end

  function automatic logic [21:0] sval(input int mode,
                                       input int r,
                                       input int c);
    logic signed [21:0] v;
    v = '0;
    case (mode)
      0: v = 22'sd1600;
      1: v = -22'sd5000;
      2: v = 22'sd8191;
      3: begin
        if (r == 2 && c == 4) v = 22'sd16;
        if (r == 2 && c == 5) v = 22'sd32;
        if (r == 3 && c == 4) v = 22'sd48;
        if (r == 3 && c == 5) v = -22'sd64;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int exp_out(input int mode, input int idx);
    case (mode)
      0: return 100;
      1: return 0;
      2: return 255;
      3: return (idx == 17) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_signal = 1'b1;
    step();
    start_signal = 1'b0;
  endtask

  task automatic clear_mon();
    out_cnt     = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    last_pv_cyc = -2;
    lat_err     = 0;
  endtask

  task automatic send(input int mode, input int n, input bit gap);
    int r;
    int c;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      if (gap) begin
        result_valid = 1'b0;
        comp_flag    = 1'b0;
        step();
      end
      result_in    = sval(mode, r, c);
      result_valid = 1'b1;
      comp_flag    = (r % 2 == 1) && (c % 2 == 1);
      step();
    end
    result_valid = 1'b0;
    comp_flag    = 1'b0;
  endtask

  task automatic run_full(input string name, input int mode, input bit gap);
    int bad;
    clear_mon();
    lat_en = 1'b1;
    do_start();
    send(mode, W * H, gap);
    repeat (3) step();
    lat_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 225; i++)
      if (outs[i] !== 8'(exp_out(mode, i))) bad++;
    check({name, "_cnt"}, out_cnt, 225);
    check({name, "_vals"}, bad, 0);
    check({name, "_done"}, done_cnt, 1);
    check({name, "_done_at_last"}, done_cyc, last_pv_cyc);
    check({name, "_ferr"}, {31'd0, frame_error}, 0);
    check({name, "_lat"}, lat_err, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start_signal = 1'b0;
    result_in    = '0;
    result_valid = 1'b0;
    conv_done    = 1'b0;
    clear_mon();
    repeat (2) step();
    check("rst_out", {24'd0, pool_out}, 0);
    check("rst_valid", {31'd0, pool_valid}, 0);
    check("rst_done", {31'd0, pool_done}, 0);
    check("rst_ferr", {31'd0, frame_error}, 0);
    rst = 1'b0;
    step();

    run_full("const", 0, 1'b0);
    check("hold_out", {24'd0, pool_out}, 100);
    run_full("neg", 1, 1'b0);
    run_full("sat", 2, 1'b0);
    run_full("maxsel", 3, 1'b0);
    check("maxsel_17", {24'd0, outs[17]}, 3);
    run_full("gap", 0, 1'b1);

    clear_mon();
    do_start();
    send(0, 500, 1'b0);
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    repeat (3) step();
    check("early_cnt", out_cnt, 120);
    check("early_done", done_cnt, 1);
    check("early_ferr", {31'd0, frame_error}, 1);
    do_start();
    check("restart_ferr", {31'd0, frame_error}, 0);

    send(0, 300, 1'b0);
    check("pre_rst_out", {24'd0, pool_out}, 100);
    rst = 1'b1;
    #1;
    clear_mon();
    check("mid_rst_out", {24'd0, pool_out}, 0);
    check("mid_rst_valid", {31'd0, pool_valid}, 0);
    check("mid_rst_ferr", {31'd0, frame_error}, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    check("mid_rst_nout", out_cnt, 0);
    check("mid_rst_ndone", done_cnt, 0);
    run_full("post_rst", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
